mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Byte-serial RAM scheduler between ICache line refill and LSB load/store. One owner per transaction.
//  Sequences multi-byte bursts over the 8-bit RAM port, assembles and extends load data, stalls IO writes
//  on io_buffer_full. LSB has fixed priority; an aging counter bounds ICache starvation.
// PARAMETERS
//  LINE_BYTES    16           ICache refill length in bytes; power of 2, 4..64
//  STARVE_LIMIT  4            consecutive LSB wins over a pending ic_req before ICache is forced
//  IO_BASE       32'h00030000 writes with addr >= IO_BASE are IO writes (stall on io_buffer_full)
// PORTS
//  clk            in   1               clock
//  rst            in   1               synchronous, active-high reset
//  rdy            in   1               global enable; low = freeze all state, mem_wr forced 0
//  mem_a          out  32              RAM byte address
//  mem_dout       out  8               RAM write data
//  mem_wr         out  1               RAM write strobe
//  mem_din        in   8               RAM read data, valid 1 cycle after address
//  io_buffer_full in   1               IO output buffer full
//  clear          in   1               pipeline flush (misprediction)
//  ic_req         in   1               ICache refill request, held until ic_done
//  ic_addr        in   32              refill base, LINE_BYTES-aligned
//  ic_done        out  1               1-cycle pulse, ic_line valid
//  ic_line        out  LINE_BYTES*8    refilled line, byte 0 in [7:0]
//  lsb_req        in   1               LSB request, held until lsb_done
//  lsb_wr         in   1               1 = store, 0 = load
//  lsb_size       in   2               0 byte, 1 half, 2/3 word
//  lsb_signed     in   1               sign-extend load result
//  lsb_addr       in   32              access base address
//  lsb_wdata      in   32              store data, byte 0 in [7:0]
//  lsb_done       out  1               1-cycle pulse; load data valid
//  lsb_rdata      out  32              extended load result
// BEHAVIOUR
//  Reset: state IDLE, cnt 0, starve 0; mem_a/mem_dout/mem_wr, ic_done, lsb_done = 0; ic_line, lsb_rdata = 0.
//  States: IDLE, IC_RD, LS_RD, LS_WR. mem_* are combinational from state/cnt; all zero in IDLE.
//  Request/done handshake:
//   - Eligible in IDLE: req high, its done not high this cycle, clear low.
//   - Both eligible: LSB wins unless starve == STARVE_LIMIT.
//     starve +1 (saturating) per LSB win with ic_req high; reset to 0 on ICache grant.
//   - Operands (addr, size, wdata) are latched at grant; later changes are ignored.
//  Reads (N = LINE_BYTES, 1, 2 or 4), cnt 0..N:
//   - cnt < N: mem_a = base + cnt.
//   - cnt >= 1: capture mem_din as byte cnt-1.
//   - At cnt == N: IDLE; done pulses the next cycle.
//   - Done is N+1 cycles after the first address cycle (LW: 5).
//   - ic_line / lsb_rdata hold until overwritten by the next completed read.
//  Writes (N = 1/2/4), cnt 0..N-1:
//   - mem_a = base + cnt, mem_dout = wdata byte cnt, mem_wr = 1.
//   - After byte N-1: IDLE; lsb_done pulses the next cycle.
//   - IO stall: io_buffer_full and address >= IO_BASE -> mem_wr = 0, cnt held, retried every cycle.
//  Extension: size 0 -> [7:0], size 1 -> [15:0]; zero-extend, or sign-extend if lsb_signed. Size 2/3: full word.
//  Address arithmetic: 32-bit wrap, no fault.
//  clear:
//   - IC_RD / LS_RD: abort -> IDLE next edge, no done pulse, captured bytes discarded.
//   - LS_WR: store completes normally, done still pulses.
//   - Done pulse in flight is not suppressed.
//  rdy low: state, cnt, starve and outputs frozen; mem_wr = 0. Resumes unchanged.
//  rst mid-transaction: immediate return to reset values; partial store bytes are not rolled back.
// TESTING
//  LW 0x100, RAM 11 22 33 44 -> lsb_rdata 0x44332211, lsb_done 5 cycles after first addr cycle
//  LB signed at byte 0x80 -> 0xFFFFFF80; LHU at 0xFF80 -> 0x0000FF80; mem_wr never high
//  SW 0xDEADBEEF @0x200 -> EF BE AD DE at 0x200..0x203, 4 cycles, lsb_done once
//  SB 0x30000 with io_buffer_full high 3 cycles -> mem_wr 0 for those cycles, one write of byte, then done
//  ic_req + lsb_req back-to-back, STARVE_LIMIT 4 -> 4 LSB grants, then ICache granted, starve reset to 0
//  clear at cnt 2 of IC_RD -> IDLE next cycle, no ic_done; clear during SW -> all 4 bytes written, done

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serial RAM scheduler shared by the ICache refill path and the LSB.
// One owner per transaction; LSB has priority, bounded by an ICache aging counter.
module mem_arbiter #(
  parameter int          LINE_BYTES   = 16,
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] IO_BASE      = 32'h00030000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  output logic [31:0]             mem_a,
  output logic [7:0]              mem_dout,
  output logic                    mem_wr,
  input  logic [7:0]              mem_din,
  input  logic                    io_buffer_full,
  input  logic                    clear,
  input  logic                    ic_req,
  input  logic [31:0]             ic_addr,
  output logic                    ic_done,
  output logic [LINE_BYTES*8-1:0] ic_line,
  input  logic                    lsb_req,
  input  logic                    lsb_wr,
  input  logic [1:0]              lsb_size,
  input  logic                    lsb_signed,
  input  logic [31:0]             lsb_addr,
  input  logic [31:0]             lsb_wdata,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata
);

  localparam int CW = $clog2(LINE_BYTES + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam int BW = $clog2(LINE_BYTES * 8);
  localparam logic [SW-1:0] SL = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IC_RD, LS_RD, LS_WR} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt, len;
  logic [SW-1:0]           starve;
  logic [31:0]             base, wdata;
  logic [1:0]              size;
  logic                    sgn;
  logic [LINE_BYTES*8-1:0] rbuf, rbuf_nxt;

  logic [31:0]   cur_a;
  logic          rd_state, stall;
  logic          lsb_ok, ic_ok, lsb_win, ic_win;
  logic [BW-1:0] bidx;
  logic [4:0]    widx;

  assign cur_a    = base + 32'(cnt);
  assign rd_state = (state == IC_RD) || (state == LS_RD);
  assign stall    = io_buffer_full && (cur_a >= IO_BASE);
  assign bidx     = BW'(cnt - 1'b1) << 3;
  assign widx     = {cnt[1:0], 3'b000};

  // a requester whose done is still high is finishing, not asking again
  assign lsb_ok  = lsb_req && !lsb_done && !clear;
  assign ic_ok   = ic_req && !ic_done && !clear;
  assign lsb_win = lsb_ok && !(ic_ok && starve == SL);
  assign ic_win  = ic_ok && !lsb_win;

  function automatic logic [CW-1:0] lsb_len(input logic [1:0] sz);
    case (sz)
      2'd0:    lsb_len = CW'(1);
      2'd1:    lsb_len = CW'(2);
      default: lsb_len = CW'(4);
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz, input logic s);
    case (sz)
      2'd0:    extend = {{24{s & w[7]}}, w[7:0]};
      2'd1:    extend = {{16{s & w[15]}}, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    case (state)
      IC_RD, LS_RD: if (cnt < len) mem_a = cur_a;
      LS_WR: begin
        mem_a    = cur_a;
        mem_dout = wdata[widx +: 8];
        mem_wr   = rdy && !stall;
      end
      default: ;
    endcase
  end

  // byte cnt-1 arrives on mem_din one cycle after its address
  always_comb begin
    rbuf_nxt = rbuf;
    if (rd_state && cnt != '0) rbuf_nxt[bidx +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      len       <= '0;
      starve    <= '0;
      base      <= '0;
      wdata     <= '0;
      size      <= '0;
      sgn       <= 1'b0;
      rbuf      <= '0;
      ic_done   <= 1'b0;
      lsb_done  <= 1'b0;
      ic_line   <= '0;
      lsb_rdata <= '0;
    end else if (rdy) begin
      ic_done  <= 1'b0;
      lsb_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (lsb_win) begin
            state <= lsb_wr ? LS_WR : LS_RD;
            base  <= lsb_addr;
            wdata <= lsb_wdata;
            size  <= lsb_size;
            sgn   <= lsb_signed;
            len   <= lsb_len(lsb_size);
            if (ic_req && starve != SL) starve <= starve + 1'b1;
          end else if (ic_win) begin
            state  <= IC_RD;
            base   <= ic_addr;
            len    <= CW'(LINE_BYTES);
            starve <= '0;
          end
        end
        IC_RD, LS_RD: begin
          rbuf <= rbuf_nxt;
          if (clear) begin
            state <= IDLE;
          end else if (cnt == len) begin
            state <= IDLE;
            if (state == IC_RD) begin
              ic_done <= 1'b1;
              ic_line <= rbuf_nxt;
            end else begin
              lsb_done  <= 1'b1;
              lsb_rdata <= extend(rbuf_nxt[31:0], size, sgn);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LS_WR: begin
          // stores ignore clear: bytes already on the bus must all land
          if (!stall) begin
            if (cnt == len - 1'b1) begin
              state    <= IDLE;
              lsb_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
